// File: rtl/micro_simd_seq.sv
// micro_simd_seq: command sequencer for the 8-lane x 4-bit micro-SIMD datapath.
// A command (op code + word count) is accepted in IDLE. That many operand
// pairs are then streamed through the external combinational datapath into a
// one-deep registered output stage with valid/ready backpressure. Per-lane
// flags are accumulated (sticky OR) for the whole command, and a one-cycle
// done pulse marks completion.
// Optional feature: define MICRO_SIMD_SEQ_PERF_EN to add the o_STALL_CNT
// output-stall counter.
module micro_simd_seq #(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_CMD_VALID,
    output logic              o_CMD_READY,
    input  logic [2:0]        i_CMD_CTRL,
    input  logic [CNT_W-1:0]  i_CMD_LEN,
    input  logic              i_OP_VALID,
    input  logic [DATA_W-1:0] i_OPA,
    input  logic [DATA_W-1:0] i_OPB,
    output logic              o_OP_READY,
    output logic [DATA_W-1:0] o_SIMD_SRC1,
    output logic [DATA_W-1:0] o_SIMD_SRC2,
    output logic [2:0]        o_SIMD_CTRL,
    input  logic [DATA_W-1:0] i_SIMD_RES,
    input  logic [DATA_W-1:0] i_SIMD_FLAGS,
    output logic              o_RES_VALID,
    output logic [DATA_W-1:0] o_RES,
    input  logic              i_RES_READY,
    output logic [DATA_W-1:0] o_FLAGS_ACC,
`ifdef MICRO_SIMD_SEQ_PERF_EN
    output logic [15:0]       o_STALL_CNT,
`endif
    output logic              o_BUSY,
    output logic              o_DONE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_next_s;
    logic [CNT_W-1:0]    count_r;
    logic [2:0]          ctrl_r;
    logic [DATA_W-1:0]   res_r;
    logic                res_valid_r;
    logic [DATA_W-1:0]   flags_r;
    logic                done_r;
    logic                busy_r;
    logic                cmd_ready_s;
    logic                op_ready_s;
    logic                cmd_fire_s;
    logic                op_fire_s;
    logic                res_drain_s;

    // Handshake readiness per state; the output stage frees up in the same
    // cycle it is drained, so RUN sustains one operand pair per cycle.
    always_comb begin
        cmd_ready_s = 1'b0;
        op_ready_s  = 1'b0;
        case (state_r)
            ST_IDLE:  cmd_ready_s = 1'b1;
            ST_RUN:   op_ready_s  = ~res_valid_r | i_RES_READY;
            default: begin
                cmd_ready_s = 1'b0;
                op_ready_s  = 1'b0;
            end
        endcase
        cmd_fire_s  = i_CMD_VALID & cmd_ready_s;
        op_fire_s   = i_OP_VALID & op_ready_s;
        res_drain_s = res_valid_r & i_RES_READY;
    end

    // Next-state logic; an empty command skips RUN so the counter never wraps.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    if (i_CMD_LEN != CNT_ZERO) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (op_fire_s && (count_r == CNT_ONE)) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!res_valid_r || i_RES_READY) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State register plus registered busy/done status outputs.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_r == ST_DONE);
        end
    end

    // Command latch: op code and remaining word count.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            ctrl_r  <= 3'b000;
            count_r <= CNT_ZERO;
        end else if (cmd_fire_s) begin
            ctrl_r  <= i_CMD_CTRL;
            count_r <= i_CMD_LEN;
        end else if (op_fire_s) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // One-deep output stage; a new accept takes priority over a plain drain.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            res_r       <= {DATA_W{1'b0}};
            res_valid_r <= 1'b0;
        end else if (op_fire_s) begin
            res_r       <= i_SIMD_RES;
            res_valid_r <= 1'b1;
        end else if (res_drain_s) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

    // Sticky flag accumulator; holds after completion until the next command.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            flags_r <= {DATA_W{1'b0}};
        end else if (cmd_fire_s) begin
            flags_r <= {DATA_W{1'b0}};
        end else if (op_fire_s) begin
            flags_r <= flags_r | i_SIMD_FLAGS;
        end else begin
            flags_r <= flags_r;
        end
    end

`ifdef MICRO_SIMD_SEQ_PERF_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles where the consumer stalls a held result.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            stall_cnt_r <= 16'h0000;
        end else if (cmd_fire_s) begin
            stall_cnt_r <= 16'h0000;
        end else if (((state_r == ST_RUN) || (state_r == ST_DRAIN)) &&
                     res_valid_r && !i_RES_READY && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign o_STALL_CNT = stall_cnt_r;
`endif

    assign o_CMD_READY = cmd_ready_s;
    assign o_OP_READY  = op_ready_s;
    assign o_SIMD_SRC1 = i_OPA;
    assign o_SIMD_SRC2 = i_OPB;
    assign o_SIMD_CTRL = ctrl_r;
    assign o_RES_VALID = res_valid_r;
    assign o_RES       = res_r;
    assign o_FLAGS_ACC = flags_r;
    assign o_BUSY      = busy_r;
    assign o_DONE      = done_r;

endmodule

// File: tb/tb_micro_simd_seq.sv
// Self-checking bench for micro_simd_seq. The datapath is stubbed as
// RES = SRC1 ^ SRC2, FLAGS = SRC1. A transaction-level reference model
// (expected-result queue, accept/consume counters, done timing) predicts
// every output each cycle.
module tb_micro_simd_seq;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_ctrl;
    logic [7:0]  cmd_len;
    logic        op_valid;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        op_ready;
    logic [31:0] simd_src1;
    logic [31:0] simd_src2;
    logic [2:0]  simd_ctrl;
    logic [31:0] simd_res;
    logic [31:0] simd_flags;
    logic        res_valid;
    logic [31:0] res;
    logic        res_ready;
    logic [31:0] flags_acc;
    logic        busy;
    logic        done;
`ifdef MICRO_SIMD_SEQ_PERF_EN
    logic [15:0] stall_cnt;
`endif

    assign simd_res   = simd_src1 ^ simd_src2;
    assign simd_flags = simd_src1;

    micro_simd_seq #(.CNT_W(8), .DATA_W(32)) dut (
        .i_CLK(clk), .i_RST(rst),
        .i_CMD_VALID(cmd_valid), .o_CMD_READY(cmd_ready),
        .i_CMD_CTRL(cmd_ctrl), .i_CMD_LEN(cmd_len),
        .i_OP_VALID(op_valid), .i_OPA(opa), .i_OPB(opb), .o_OP_READY(op_ready),
        .o_SIMD_SRC1(simd_src1), .o_SIMD_SRC2(simd_src2), .o_SIMD_CTRL(simd_ctrl),
        .i_SIMD_RES(simd_res), .i_SIMD_FLAGS(simd_flags),
        .o_RES_VALID(res_valid), .o_RES(res), .i_RES_READY(res_ready),
        .o_FLAGS_ACC(flags_acc),
`ifdef MICRO_SIMD_SEQ_PERF_EN
        .o_STALL_CNT(stall_cnt),
`endif
        .o_BUSY(busy), .o_DONE(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit          active;
    int          len;
    int          acc_n;
    int          cons_n;
    logic [31:0] exp_q[$];
    logic [31:0] m_flags;
    logic [2:0]  m_ctrl;
    int          m_stall;
    int          cyc;
    int          done_at;
    int          n_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        active  = 1'b0;
        len     = 0;
        acc_n   = 0;
        cons_n  = 0;
        exp_q.delete();
        m_flags = 32'h0;
        m_ctrl  = 3'b000;
        m_stall = 0;
        done_at = -1;
    endtask

    // One clock cycle: drive at posedge+1, check at the falling edge, advance model.
    task automatic step(input logic cv, input logic [2:0] cc, input logic [7:0] cl,
                        input logic opv, input logic [31:0] a, input logic [31:0] b,
                        input logic rr);
        bit exp_valid;
        bit exp_opr;
        cmd_valid = cv; cmd_ctrl = cc; cmd_len = cl;
        op_valid = opv; opa = a; opb = b; res_ready = rr;
        #4;
        if (cyc == done_at) active = 1'b0;
        exp_valid = ((acc_n - cons_n) == 1);
        exp_opr   = active && (acc_n < len) && (!exp_valid || rr);
        chk("cmd_ready", 32'(cmd_ready), 32'(!active));
        chk("busy",      32'(busy),      32'(active));
        chk("op_ready",  32'(op_ready),  32'(exp_opr));
        chk("res_valid", 32'(res_valid), 32'(exp_valid));
        if (exp_valid) chk("res", res, exp_q[0]);
        chk("flags_acc", flags_acc, m_flags);
        chk("simd_ctrl", 32'(simd_ctrl), 32'(m_ctrl));
        chk("done",      32'(done),      32'(cyc == done_at));
        chk("simd_src1", simd_src1, a);
`ifdef MICRO_SIMD_SEQ_PERF_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        if (done === 1'b1) n_done++;
        if (active && exp_valid && !rr && m_stall < 65535) m_stall++;
        if (exp_valid && rr) begin
            void'(exp_q.pop_front());
            cons_n++;
            if (cons_n == len) done_at = cyc + 2;
        end
        if (opv && exp_opr) begin
            exp_q.push_back(a ^ b);
            m_flags = m_flags | a;
            acc_n++;
        end
        if (cv && !active) begin
            active = 1'b1; len = int'(cl); acc_n = 0; cons_n = 0;
            exp_q.delete(); m_flags = 32'h0; m_ctrl = cc; m_stall = 0;
            if (cl == 8'd0) done_at = cyc + 2;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 8'd0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'h0);
        chk({tag, "_res"},       res,            32'h0);
        chk({tag, "_flags"},     flags_acc,      32'h0);
        chk({tag, "_busy"},      32'(busy),      32'h0);
        chk({tag, "_done"},      32'(done),      32'h0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
        chk({tag, "_op_ready"},  32'(op_ready),  32'h0);
        chk({tag, "_ctrl"},      32'(simd_ctrl), 32'h0);
    endtask

    initial begin
        int base_done;
        int n;
        logic        r_opv;
        logic        r_rr;
        logic [31:0] r_a;
        logic [31:0] r_b;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_ctrl = 3'b000; cmd_len = 8'd0;
        op_valid = 1'b0; opa = 32'h0; opb = 32'h0; res_ready = 1'b0;
        cyc = 0; n_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("por");
        rst = 1'b0;
        idle(3);

        // T1: three back-to-back ops with consumer always ready
        base_done = n_done;
        step(1'b1, 3'b010, 8'd3, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 3'b000, 8'd0, 1'b1, 32'h0000_000F, 32'h0000_0001, 1'b1);
        step(1'b0, 3'b000, 8'd0, 1'b1, 32'h1111_1111, 32'h1111_1111, 1'b1);
        step(1'b0, 3'b000, 8'd0, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b1);
        idle(4);
        chk("t1_flags", flags_acc, 32'h9111_111F);
        chk("t1_ctrl", 32'(simd_ctrl), 32'h2);
        chk("t1_complete", 32'(active), 32'h0);
        chk("t1_done_count", 32'(n_done - base_done), 32'h1);

        // T2: same command, consumer stalls 4 cycles after the first result
        base_done = n_done;
        step(1'b1, 3'b010, 8'd3, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 3'b000, 8'd0, 1'b1, 32'h0000_000F, 32'h0000_0001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'b000, 8'd0, 1'b1, 32'h1111_1111, 32'h1111_1111, 1'b0);
            chk("t2_held", res, 32'h0000_000E);
        end
        step(1'b0, 3'b000, 8'd0, 1'b1, 32'h1111_1111, 32'h1111_1111, 1'b1);
        step(1'b0, 3'b000, 8'd0, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b1);
        idle(4);
        chk("t2_flags", flags_acc, 32'h9111_111F);
        chk("t2_results", 32'(cons_n), 32'h3);
        chk("t2_done_count", 32'(n_done - base_done), 32'h1);
`ifdef MICRO_SIMD_SEQ_PERF_EN
        chk("t2_stall", 32'(stall_cnt), 32'h4);
`endif

        // T3: empty command while operands are offered (must be ignored)
        base_done = n_done;
        step(1'b1, 3'b111, 8'd0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 3'b000, 8'd0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        chk("t3_flags", flags_acc, 32'h0);
        chk("t3_done_count", 32'(n_done - base_done), 32'h1);
        idle(2);

        // T4: asynchronous reset while the second of three results is valid
        base_done = n_done;
        step(1'b1, 3'b101, 8'd3, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 3'b000, 8'd0, 1'b1, 32'h0000_00F0, 32'h0000_0F00, 1'b1);
        step(1'b0, 3'b000, 8'd0, 1'b1, 32'h0A0A_0A0A, 32'h0000_0000, 1'b1);
        chk("t4_pre_valid", 32'(res_valid), 32'h1);
        cmd_valid = 1'b0; op_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_reset_values("t4_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc++;
        idle(4);
        chk("t4_no_done", 32'(n_done - base_done), 32'h0);
        step(1'b1, 3'b001, 8'd2, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 3'b000, 8'd0, 1'b1, 32'h0000_0003, 32'h0000_0005, 1'b1);
        step(1'b0, 3'b000, 8'd0, 1'b1, 32'h0000_0010, 32'h0000_0001, 1'b1);
        idle(4);
        chk("t4_new_cmd_done", 32'(n_done - base_done), 32'h1);
        chk("t4_flags", flags_acc, 32'h0000_0013);

        // T5: maximum-length command with random valid/ready
        base_done = n_done;
        step(1'b1, 3'b011, 8'd255, 1'b0, 32'h0, 32'h0, 1'b1);
        n = 0;
        while (active && n < 4000) begin
            r_opv = 1'($urandom_range(1, 0));
            r_rr  = 1'($urandom_range(1, 0));
            r_a   = $urandom;
            r_b   = $urandom;
            step(1'b0, 3'b000, 8'd0, r_opv, r_a, r_b, r_rr);
            n++;
        end
        chk("t5_complete", 32'(active), 32'h0);
        chk("t5_results", 32'(cons_n), 32'd255);
        chk("t5_done_count", 32'(n_done - base_done), 32'h1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/micro_simd_seq.md
Name: micro_simd_seq

Overview:
- Command sequencer for the 8-lane x 4-bit combinational micro-SIMD datapath.
- Accepts a command (3-bit SIMD op code, word count) from the core-side decoder, then streams that many 32-bit operand pairs through the datapath.
- Registers each result into a one-deep output stage with valid/ready backpressure.
- Accumulates sticky per-lane flags for the command and pulses done on completion.

Parameters:
- CNT_W, 8, width of command length field and internal word counter.
- DATA_W, 32, operand/result width (8 lanes x 4 bits); flag bus also DATA_W (4 flags per lane).

Ports:
- i_CLK  in  1  clock, all state on rising edge.
- i_RST  in  1  asynchronous, active-high reset.
- i_CMD_VALID  in  1  command offered.
- o_CMD_READY  out  1  command accepted when VALID&READY.
- i_CMD_CTRL  in  3  SIMD op code for the whole command.
- i_CMD_LEN  in  CNT_W  number of operand pairs; 0 = empty command.
- i_OP_VALID  in  1  operand pair offered.
- i_OPA  in  DATA_W  operand 1.
- i_OPB  in  DATA_W  operand 2.
- o_OP_READY  out  1  operand pair accepted when VALID&READY.
- o_SIMD_SRC1  out  DATA_W  to datapath src1 (= i_OPA, combinational).
- o_SIMD_SRC2  out  DATA_W  to datapath src2 (= i_OPB, combinational).
- o_SIMD_CTRL  out  3  to datapath ctrl (latched op code).
- i_SIMD_RES  in  DATA_W  datapath result.
- i_SIMD_FLAGS  in  DATA_W  datapath flags {N,Z,C,V} per lane.
- o_RES_VALID  out  1  result register holds valid data.
- o_RES  out  DATA_W  registered result.
- i_RES_READY  in  1  consumer accepts result.
- o_FLAGS_ACC  out  DATA_W  sticky OR of flags for the current/last command.
- o_BUSY  out  1  high whenever state != IDLE.
- o_DONE  out  1  one-cycle completion pulse.

Behaviour:
- Single clock i_CLK; reset i_RST is asynchronous and active-high.
- Reset values: state=IDLE, count=0, ctrl=0, o_RES=0, o_RES_VALID=0, o_FLAGS_ACC=0, o_DONE=0, o_BUSY=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - o_CMD_READY=1, o_OP_READY=0.
  - On command accept: latch ctrl, count<=i_CMD_LEN, o_FLAGS_ACC<=0.
  - Next state is RUN if LEN!=0, else DONE.
- RUN:
  - o_CMD_READY=0.
  - o_OP_READY = !o_RES_VALID | i_RES_READY (single-entry pipeline, full throughput).
  - On op accept, same edge: o_RES<=i_SIMD_RES, o_RES_VALID<=1, o_FLAGS_ACC<=o_FLAGS_ACC|i_SIMD_FLAGS, count<=count-1.
  - If count==1 at accept, next state is DRAIN.
  - Latency: operand accept to o_RES_VALID is 1 cycle.
- Output stage (all states):
  - i_RES_READY&o_RES_VALID with no new op accept clears o_RES_VALID.
  - Simultaneous drain and op accept keeps o_RES_VALID=1 with the new data.
- DRAIN:
  - o_OP_READY=0.
  - When o_RES_VALID=0, or is being cleared this cycle, go to DONE.
- DONE:
  - o_DONE=1 for exactly one cycle, then IDLE.
  - o_FLAGS_ACC holds until the next command accept.
- o_SIMD_CTRL is driven from the latched ctrl in every state; it does not change during a command.
- o_OP_READY is never asserted outside RUN; operands offered in IDLE/DRAIN/DONE are ignored (not consumed).
- Count is CNT_W bits; maximum command is 2^CNT_W-1 pairs. No wrap occurs because LEN==0 bypasses RUN.
- Reset mid-command: aborts immediately to reset values; the pending result is discarded and no o_DONE pulse is produced.

Optional Feature:
- Macro: MICRO_SIMD_SEQ_PERF_EN.
- Defined:
  - Adds output o_STALL_CNT (16 bits) counting cycles in RUN or DRAIN with o_RES_VALID=1 and i_RES_READY=0.
  - Saturates at 16'hFFFF, clears on command accept, resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Bench stub: RES=SRC1^SRC2, FLAGS=SRC1.
- Reset then idle: o_CMD_READY=1, o_BUSY=0, o_RES_VALID=0, o_FLAGS_ACC=0, no o_DONE.
- CMD(ctrl=3'b010, LEN=3), ops (32'h0000_000F,32'h0000_0001), (32'h1111_1111,32'h1111_1111), (32'h8000_0000,0), i_RES_READY=1 -> o_SIMD_CTRL=3'b010; results 32'h0000_000E, 0, 32'h8000_0000 each 1 cycle after accept, back-to-back; o_FLAGS_ACC=32'h9111_111F; one o_DONE after the last result drains.
- Same command with i_RES_READY=0 for 4 cycles after the first result -> o_OP_READY=0, o_RES held at 32'h0000_000E; no result lost or duplicated; PERF_EN build gives o_STALL_CNT=4.
- CMD LEN=0 -> no o_OP_READY; o_DONE 2 cycles after accept (IDLE->DONE->pulse); o_FLAGS_ACC=0.
- Assert i_RST after the 2nd of 3 ops in the same cycle as o_RES_VALID -> all outputs return to reset values asynchronously; no o_DONE; a new CMD is accepted normally.
- CMD LEN=255 with random i_OP_VALID/i_RES_READY -> exactly 255 results in order; o_DONE once; o_CMD_READY=0 throughout.
